// File: rtl/signed_mult_seq_pkg.sv
// Shared types and constants for the sequential signed multiplier.
package signed_mult_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/signed_mult_seq_negate.sv
// Combinational two's-complement negator: negated = ~value + 1.
module twos_negate #(
   parameter int W = 4
) (
   input  logic [W-1:0] value,
   output logic [W-1:0] negated
);

   assign negated = ~value + 1'b1;

endmodule

// File: rtl/signed_mult_seq.sv
// Multi-cycle signed multiplier: magnitude shift-add over WIDTH cycles, then sign fix.
module signed_mult_seq
   import signed_mult_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic signed [WIDTH-1:0]     a,
   input  logic signed [WIDTH-1:0]     b,
   output logic                        busy,
   output logic                        done,
   output logic signed [2*WIDTH-1:0]   product
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t               state, state_next;
   logic [WIDTH-1:0]     ma, mb;
   logic [WIDTH-1:0]     neg_a, neg_b, mag_a, mag_b;
   logic [2*WIDTH-1:0]   acc, acc_neg, addend;
   logic [CNT_W-1:0]     cnt;
   logic                 neg;

   twos_negate #(.W(WIDTH))   u_neg_a   (.value(a),   .negated(neg_a));
   twos_negate #(.W(WIDTH))   u_neg_b   (.value(b),   .negated(neg_b));
   twos_negate #(.W(2*WIDTH)) u_neg_acc (.value(acc), .negated(acc_neg));

   // The most-negative operand negates to itself, which read as unsigned is the right magnitude.
   assign mag_a = a[WIDTH-1] ? neg_a : a;
   assign mag_b = b[WIDTH-1] ? neg_b : b;

   always_comb begin
      addend = '0;
      if (mb[cnt]) addend = {{WIDTH{1'b0}}, ma} << cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = MULT;
         MULT:    if (cnt == CNT_LAST) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma      <= '0;
         mb      <= '0;
         neg     <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  ma  <= mag_a;
                  mb  <= mag_b;
                  neg <= a[WIDTH-1] ^ b[WIDTH-1];
                  acc <= '0;
                  cnt <= '0;
               end
            end
            MULT: begin
               acc <= acc + addend;
               cnt <= cnt + 1'b1;
            end
            // A zero magnitude negates to zero, so -0 needs no special case.
            FIX: product <= neg ? acc_neg : acc;
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_signed_mult_seq.sv
// Scoreboard bench for signed_mult_seq at WIDTH=4.
module tb_signed_mult_seq;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [3:0]        a, b;
   logic              busy, done;
   logic [7:0]        product;

   logic [7:0]        sb[$];
   int                vectors;
   int                miscompares;

   signed_mult_seq #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
      int p;
      p = $signed(x) * $signed(y);
      return p[7:0];
   endfunction

   // Output monitor: every done pulse pops one expected product.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) check_val("spurious_done", 32'd1, 32'd0);
         else check_val("product", {24'b0, product}, {24'b0, sb.pop_front()});
      end
   end

   task automatic wait_done(input string tag, output int n);
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (done) seen = 1;
      end
      if (!seen) check_val(tag, 32'd0, 32'd1);
   endtask

   task automatic do_op(input logic [3:0] x, input logic [3:0] y);
      int n;
      @(negedge clk);
      check_val("done_low_before", {31'b0, done}, 32'd0);
      a = x; b = y; start = 1'b1;
      sb.push_back(ref_mul(x, y));
      @(negedge clk);
      start = 1'b0;
      check_val("busy_after_start", {31'b0, busy}, 32'd1);
      wait_done("done_timeout", n);
      check_val("latency", n, 32'd5);
      check_val("busy_at_done", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      logic [3:0] ops_a[4];
      logic [3:0] ops_b[4];
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check_val("reset_busy", {31'b0, busy}, 32'd0);
      check_val("reset_done", {31'b0, done}, 32'd0);
      check_val("reset_product", {24'b0, product}, 32'd0);
      rst_n = 1'b1;

      do_op(4'd3, 4'd5);
      do_op(4'hD, 4'd5);
      do_op(4'hD, 4'hB);
      do_op(4'h8, 4'h8);
      do_op(4'd7, 4'h8);
      do_op(4'd0, 4'hF);

      // Restart attempts while busy must be ignored.
      @(negedge clk);
      a = 4'd2; b = 4'd3; start = 1'b1;
      sb.push_back(ref_mul(4'd2, 4'd3));
      @(negedge clk);
      a = 4'd1; b = 4'd1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done("restart_timeout", n);
      check_val("restart_latency", n, 32'd3);
      repeat (10) @(negedge clk);
      check_val("restart_product_held", {24'b0, product}, 32'h06);

      // Asynchronous reset mid-operation discards the operation.
      @(negedge clk);
      a = 4'd3; b = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("midreset_busy", {31'b0, busy}, 32'd0);
      check_val("midreset_done", {31'b0, done}, 32'd0);
      check_val("midreset_product", {24'b0, product}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check_val("midreset_idle", {31'b0, busy}, 32'd0);
      do_op(4'd3, 4'd5);

      // Back-to-back with start held high; new operands in each done cycle.
      ops_a = '{4'd7, 4'hA, 4'h8, 4'd5};
      ops_b = '{4'd6, 4'd3, 4'd7, 4'hC};
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = ops_a[i]; b = ops_b[i];
         sb.push_back(ref_mul(ops_a[i], ops_b[i]));
         wait_done("b2b_timeout", n);
      end
      start = 1'b0;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            do_op(4'(i), 4'(j));

      repeat (3) @(negedge clk);
      check_val("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
